tx_fifo: RTL and testbench



---
 rtl/ssp_pkg.sv | 11 +
 rtl/ssp_fifo_mem.sv | 29 ++
 rtl/tx_fifo.sv | 98 +++++++++
 tb/tb_tx_fifo.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/ssp_pkg.sv
// Shared definitions for the synchronous serial port: data width, FIFO
// geometry and the byte type used by the transmit/receive FIFOs and shifters.
package ssp_pkg;

   localparam int SSP_DATA_WIDTH = 8;
   localparam int SSP_FIFO_DEPTH = 4;
   localparam int SSP_FIFO_AW    = 2;

   typedef logic [SSP_DATA_WIDTH-1:0] ssp_byte_t;

endpackage

// File: rtl/ssp_fifo_mem.sv
// DEPTH x DATA_WIDTH register array, one synchronous write port and one
// asynchronous read port; shared by the transmit and receive FIFOs.
module ssp_fifo_mem
   import ssp_pkg::*;
#(
   parameter int DATA_WIDTH = SSP_DATA_WIDTH,
   parameter int DEPTH      = SSP_FIFO_DEPTH,
   parameter int ADDR_WIDTH = SSP_FIFO_AW
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem_r [DEPTH];

   // Storage write; contents deliberately survive reset
   always_ff @(posedge clk) begin
      if (we) begin
         mem_r[waddr] <= wdata;
      end
   end

   assign rdata = mem_r[raddr];

endmodule

// File: rtl/tx_fifo.sv
// Transmit FIFO of the serial port: APB pushes, shifter pops, show-ahead head.
// Define TX_OVERFLOW_FLAG_EN to get a sticky lost-write flag on tx_ovf.
module tx_fifo
   import ssp_pkg::*;
#(
   parameter int DATA_WIDTH = SSP_DATA_WIDTH,
   parameter int DEPTH      = SSP_FIFO_DEPTH,
   parameter int ADDR_WIDTH = SSP_FIFO_AW
) (
   input  logic                  pclk,
   input  logic                  clear,
   input  logic                  psel,
   input  logic                  pwrite,
   input  logic [DATA_WIDTH-1:0] pwdata,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] txdata,
   output logic                  tx_empty,
   output logic                  ssptxintr,
   output logic                  tx_ovf
);

   localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = ADDR_WIDTH'(1'b1);
   localparam logic [ADDR_WIDTH:0]   CNT_ONE    = (ADDR_WIDTH+1)'(1'b1);
   localparam logic [ADDR_WIDTH:0]   FULL_COUNT = (ADDR_WIDTH+1)'(DEPTH);

   logic [ADDR_WIDTH-1:0] wr_ptr_r;
   logic [ADDR_WIDTH-1:0] rd_ptr_r;
   logic [ADDR_WIDTH:0]   count_r;
   logic [ADDR_WIDTH:0]   count_nxt_s;
   logic                  push_s;
   logic                  pop_s;
   logic [DATA_WIDTH-1:0] head_s;

   // Flags come from registered count, so push/pop qualification never loops
   assign tx_empty  = (count_r == '0);
   assign ssptxintr = (count_r == FULL_COUNT);
   assign push_s    = psel & pwrite & ~ssptxintr;
   assign pop_s     = rd_en & ~tx_empty;
   assign txdata    = tx_empty ? '0 : head_s;

   ssp_fifo_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_mem (
      .clk   (pclk),
      .we    (push_s),
      .waddr (wr_ptr_r),
      .wdata (pwdata),
      .raddr (rd_ptr_r),
      .rdata (head_s)
   );

   // Occupancy change for each push/pop combination
   always_comb begin
      count_nxt_s = count_r;
      case ({push_s, pop_s})
         2'b10:   count_nxt_s = count_r + CNT_ONE;
         2'b01:   count_nxt_s = count_r - CNT_ONE;
         default: count_nxt_s = count_r;
      endcase
   end

   // Pointer and occupancy registers; power-of-two depth wraps naturally
   always_ff @(posedge pclk) begin
      if (clear) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         count_r <= count_nxt_s;
      end
   end

`ifdef TX_OVERFLOW_FLAG_EN
   logic ovf_r;

   // Sticky record of a write lost to a full FIFO that no pop relieved
   always_ff @(posedge pclk) begin
      if (clear) begin
         ovf_r <= 1'b0;
      end else if (psel & pwrite & ssptxintr & ~rd_en) begin
         ovf_r <= 1'b1;
      end
   end

   assign tx_ovf = ovf_r;
`else
   assign tx_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_tx_fifo.sv
// Self-checking bench for tx_fifo: queue model checked every cycle plus
// directed literal expectations; honours TX_OVERFLOW_FLAG_EN when defined.
module tb_tx_fifo;

   localparam int DEPTH = 4;
`ifdef TX_OVERFLOW_FLAG_EN
   localparam bit OVF_EN = 1'b1;
`else
   localparam bit OVF_EN = 1'b0;
`endif

   logic       pclk = 1'b0;
   logic       clear, psel, pwrite, rd_en;
   logic [7:0] pwdata;
   logic [7:0] txdata;
   logic       tx_empty, ssptxintr, tx_ovf;

   int checks   = 0;
   int failures = 0;

   logic [7:0] mq[$];
   logic       m_ovf   = 1'b0;
   bit         m_valid = 1'b0;

   always #5 pclk = ~pclk;

   tx_fifo dut (
      .pclk      (pclk),
      .clear     (clear),
      .psel      (psel),
      .pwrite    (pwrite),
      .pwdata    (pwdata),
      .rd_en     (rd_en),
      .txdata    (txdata),
      .tx_empty  (tx_empty),
      .ssptxintr (ssptxintr),
      .tx_ovf    (tx_ovf)
   );

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a queue of bytes, full/empty judged before the edge
   always @(posedge pclk) begin
      if (clear) begin
         mq.delete();
         m_ovf   = 1'b0;
         m_valid = 1'b1;
      end else begin
         bit was_full, was_empty;
         was_full  = (mq.size() == DEPTH);
         was_empty = (mq.size() == 0);
         if (OVF_EN && psel && pwrite && was_full && !rd_en) m_ovf = 1'b1;
         if (rd_en && !was_empty) void'(mq.pop_front());
         if (psel && pwrite && !was_full) mq.push_back(pwdata);
      end
   end

   // Every-cycle comparison against the model, away from the active edge
   always @(negedge pclk) begin
      if (m_valid) begin
         check("m_empty", {7'd0, tx_empty},  {7'd0, mq.size() == 0});
         check("m_full",  {7'd0, ssptxintr}, {7'd0, mq.size() == DEPTH});
         check("m_data",  txdata, (mq.size() == 0) ? 8'h00 : mq[0]);
         check("m_ovf",   {7'd0, tx_ovf},    {7'd0, m_ovf});
      end
   end

   task automatic cyc(input logic c, input logic s, input logic w,
                      input logic [7:0] d, input logic r);
      clear = c; psel = s; pwrite = w; pwdata = d; rd_en = r;
      @(posedge pclk);
      #1;
   endtask

   task automatic push(input logic [7:0] d);
      cyc(1'b0, 1'b1, 1'b1, d, 1'b0);
   endtask

   task automatic pop();
      cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
   endtask

   task automatic idle();
      cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
   endtask

   initial begin
      logic [7:0] e;
      clear = 1'b1; psel = 1'b0; pwrite = 1'b0; pwdata = 8'h00; rd_en = 1'b0;

      // Reset held two cycles with a write pending
      cyc(1'b1, 1'b1, 1'b1, 8'hAA, 1'b0);
      cyc(1'b1, 1'b1, 1'b1, 8'hAA, 1'b0);
      check("rst_empty", {7'd0, tx_empty},  8'h01);
      check("rst_full",  {7'd0, ssptxintr}, 8'h00);
      check("rst_data",  txdata,            8'h00);
      check("rst_ovf",   {7'd0, tx_ovf},    8'h00);
      idle();
      check("rst_noenq", {7'd0, tx_empty},  8'h01);

      // Fill
      push(8'h01);
      check("fill_head", txdata, 8'h01);
      check("fill_nempty", {7'd0, tx_empty}, 8'h00);
      push(8'h02);
      push(8'h03);
      check("fill_notfull", {7'd0, ssptxintr}, 8'h00);
      push(8'h04);
      check("fill_full", {7'd0, ssptxintr}, 8'h01);

      // Overflow attempt
      push(8'h05);
      check("ovf_full", {7'd0, ssptxintr}, 8'h01);
      check("ovf_head", txdata, 8'h01);
      check("ovf_flag", {7'd0, tx_ovf}, {7'd0, OVF_EN});
      pop();
      check("drain_1", txdata, 8'h02);
      pop();
      check("drain_2", txdata, 8'h03);
      pop();
      check("drain_3", txdata, 8'h04);
      pop();
      check("drain_empty", {7'd0, tx_empty}, 8'h01);
      check("drain_data", txdata, 8'h00);
      pop();
      check("pop_empty_ign", {7'd0, tx_empty}, 8'h01);

      // Full + write + pop: only the pop happens
      push(8'h11); push(8'h12); push(8'h13); push(8'h14);
      cyc(1'b0, 1'b1, 1'b1, 8'h10, 1'b1);
      check("fp_notfull", {7'd0, ssptxintr}, 8'h00);
      check("fp_head", txdata, 8'h12);
      pop();
      check("fp_d1", txdata, 8'h13);
      pop();
      check("fp_d2", txdata, 8'h14);
      pop();
      check("fp_gone", {7'd0, tx_empty}, 8'h01);

      // Empty + write + rd_en: only the push happens
      cyc(1'b0, 1'b1, 1'b1, 8'h20, 1'b1);
      check("ep_head", txdata, 8'h20);
      check("ep_nempty", {7'd0, tx_empty}, 8'h00);
      pop();
      check("ep_drained", {7'd0, tx_empty}, 8'h01);

      // Wrap: keep up to three resident, ten bytes through
      push(8'h30); push(8'h31); push(8'h32);
      for (int i = 0; i < 10; i++) begin
         e = 8'h30 + 8'(i);
         check("wrap_order", txdata, e);
         if (i + 3 <= 9) cyc(1'b0, 1'b1, 1'b1, 8'h33 + 8'(i), 1'b1);
         else pop();
      end
      check("wrap_empty", {7'd0, tx_empty}, 8'h01);

      // Reset mid-operation with pop and write active
      push(8'h40); push(8'h41); push(8'h42);
      cyc(1'b1, 1'b1, 1'b1, 8'h77, 1'b1);
      check("mrst_empty", {7'd0, tx_empty},  8'h01);
      check("mrst_full",  {7'd0, ssptxintr}, 8'h00);
      check("mrst_ovf",   {7'd0, tx_ovf},    8'h00);
      check("mrst_data",  txdata,            8'h00);
      push(8'h55);
      check("mrst_push", txdata, 8'h55);
      idle();
      idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
